// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - multi-cycle stage sequencer for the single-issue core
//
// Steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB,
// issuing one-cycle stage enables and handling imem/dmem request/ready
// handshakes, run/halt control and a retired-instruction counter.
//
// Optional feature: define SEQ_TIMEOUT_EN to bound FETCH/MEM waits to
// TIMEOUT_CYCLES; an expired wait moves the sequencer into a sticky FAULT.
// Without it waits are unbounded and o_fault is always 0.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_run                   level, 1 = execute instructions
//   i_halt_req              request halt after the current instruction retires
//   i_imem_ready            instruction memory data valid (honoured in FETCH)
//   i_is_mem_op             decoded op is load/store (sampled in DECODE)
//   i_dmem_ready            data access complete (honoured in MEM)
//   o_imem_req, o_dmem_req  memory requests
//   o_en_IF..o_en_WB        mutually exclusive one-cycle stage strobes
//   o_state                 current state encoding
//   o_busy, o_halted, o_fault  status
//   o_instr_count           retired instructions, wraps

module core_seq_ctrl #(
  parameter int COUNT_W        = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_run,
  input  logic               i_halt_req,
  input  logic               i_imem_ready,
  input  logic               i_is_mem_op,
  input  logic               i_dmem_ready,
  output logic               o_imem_req,
  output logic               o_dmem_req,
  output logic               o_en_IF,
  output logic               o_en_ID,
  output logic               o_en_EX,
  output logic               o_en_MEM,
  output logic               o_en_WB,
  output logic [2:0]         o_state,
  output logic               o_busy,
  output logic               o_halted,
  output logic               o_fault,
  output logic [COUNT_W-1:0] o_instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_e;

  if (COUNT_W < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("core_seq_ctrl: COUNT_W and TIMEOUT_CYCLES must be at least 1");
  end

  state_e             state_q, state_d;
  logic               halt_pending_q, halt_pending_d;
  logic               mem_pending_q, mem_pending_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               wait_expired;

`ifdef SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              waiting;

  // A wait cycle is a FETCH/MEM cycle whose matching ready is low.
  assign waiting = ((state_q == S_FETCH) && !i_imem_ready) ||
                   ((state_q == S_MEM)   && !i_dmem_ready);

  // wait_q counts previous wait cycles, so this fires on the
  // TIMEOUT_CYCLES-th consecutive wait cycle; ready high wins because
  // waiting is then 0.
  assign wait_expired = waiting && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (waiting) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign wait_expired = 1'b0;
`endif

  // State register plus the datapath flops that move with it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q        <= S_IDLE;
      halt_pending_q <= 1'b0;
      mem_pending_q  <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      halt_pending_q <= halt_pending_d;
      mem_pending_q  <= mem_pending_d;
      count_q        <= count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_halt_req) begin
          state_d = S_HALT;
        end else if (i_run) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (i_imem_ready) begin
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = mem_pending_q ? S_MEM : S_WB;
      S_MEM: begin
        if (i_dmem_ready) begin
          state_d = S_WB;
        end else if (wait_expired) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        // A halt request arriving in WB itself is taken at this retirement.
        if (halt_pending_q || i_halt_req) begin
          state_d = S_HALT;
        end else if (!i_run) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (!i_run) begin
          state_d = S_IDLE;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky halt request, mem-op latch and retirement counter.
  always_comb begin
    halt_pending_d = halt_pending_q;
    if (i_halt_req && (state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB})) begin
      halt_pending_d = 1'b1;
    end
    if (state_d == S_HALT) begin
      halt_pending_d = 1'b0;
    end

    mem_pending_d = (state_q == S_DECODE) ? i_is_mem_op : mem_pending_q;

    count_d = count_q;
    if (state_q == S_WB) begin
      count_d = count_q + 1'b1;
    end
  end

  // Output decode; IF and MEM strobes follow ready combinationally.
  always_comb begin
    o_imem_req = 1'b0;
    o_dmem_req = 1'b0;
    o_en_IF    = 1'b0;
    o_en_ID    = 1'b0;
    o_en_EX    = 1'b0;
    o_en_MEM   = 1'b0;
    o_en_WB    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        o_imem_req = 1'b1;
        o_en_IF    = i_imem_ready;
      end
      S_DECODE: o_en_ID = 1'b1;
      S_EXEC:   o_en_EX = 1'b1;
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_en_MEM   = i_dmem_ready;
      end
      S_WB:     o_en_WB = 1'b1;
      default: ;
    endcase
  end

  assign o_state       = state_q;
  assign o_busy        = !(state_q inside {S_IDLE, S_HALT, S_FAULT});
  assign o_halted      = (state_q == S_HALT);
  assign o_fault       = (state_q == S_FAULT);
  assign o_instr_count = count_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb/tb_core_seq_ctrl.sv - self-checking bench for core_seq_ctrl

module tb_core_seq_ctrl;

  localparam int COUNT_W        = 4;
  localparam int TIMEOUT_CYCLES = 8;

  logic               i_clk = 1'b0;
  logic               i_reset = 1'b1;
  logic               i_run = 1'b0;
  logic               i_halt_req = 1'b0;
  logic               i_imem_ready = 1'b0;
  logic               i_is_mem_op = 1'b0;
  logic               i_dmem_ready = 1'b0;
  logic               o_imem_req, o_dmem_req;
  logic               o_en_IF, o_en_ID, o_en_EX, o_en_MEM, o_en_WB;
  logic [2:0]         o_state;
  logic               o_busy, o_halted, o_fault;
  logic [COUNT_W-1:0] o_instr_count;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;

  always #5 i_clk = ~i_clk;

  core_seq_ctrl #(.COUNT_W(COUNT_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_halt_req(i_halt_req),
    .i_imem_ready(i_imem_ready), .i_is_mem_op(i_is_mem_op), .i_dmem_ready(i_dmem_ready),
    .o_imem_req(o_imem_req), .o_dmem_req(o_dmem_req),
    .o_en_IF(o_en_IF), .o_en_ID(o_en_ID), .o_en_EX(o_en_EX), .o_en_MEM(o_en_MEM),
    .o_en_WB(o_en_WB), .o_state(o_state), .o_busy(o_busy), .o_halted(o_halted),
    .o_fault(o_fault), .o_instr_count(o_instr_count)
  );

  // {state, imem_req, dmem_req, IF, ID, EX, MEM, WB}
  function automatic logic [9:0] obs();
    return {o_state, o_imem_req, o_dmem_req, o_en_IF, o_en_ID, o_en_EX, o_en_MEM, o_en_WB};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_run = 1'b0;
    i_halt_req = 1'b0;
    i_imem_ready = 1'($urandom);
    i_dmem_ready = 1'($urandom);
    i_is_mem_op = 1'($urandom);
    tick();
    i_reset = 1'b0;
    exp_count = 0;
  endtask

  task automatic check_state(input string name, input logic [2:0] exp_state,
                             input logic exp_busy, input logic exp_halted, input logic exp_fault);
    checks++;
    if (o_state !== exp_state || o_busy !== exp_busy || o_halted !== exp_halted || o_fault !== exp_fault) begin
      failures++;
      $display("FAIL %s: state=%0d busy=%b halted=%b fault=%b, expected state=%0d busy=%b halted=%b fault=%b",
               name, o_state, o_busy, o_halted, o_fault, exp_state, exp_busy, exp_halted, exp_fault);
    end
  endtask

  // One IDLE cycle with run high, landing in FETCH.
  task automatic start_run();
    i_run = 1'b1;
    i_halt_req = 1'b0;
    @(negedge i_clk);
    checks++;
    if (obs() !== 10'd0) begin
      failures++;
      $display("FAIL start_idle: got %b expected %b", obs(), 10'd0);
    end
    tick();
  endtask

  // Runs one instruction from FETCH through WB. The expected per-cycle
  // trace is built from the stage rules: iw stalled fetch cycles, fetch,
  // decode, exec, optionally dw stalled mem cycles plus mem, then WB.
  // Ready lines are random wherever the matching request is not expected.
  task automatic run_instr(input bit mem, input int iw, input int dw,
                           input int halt_at, input bit run_wb);
    logic [9:0] exp_q[$];
    int dstart;
    int wb_idx;
    for (int k = 0; k < iw; k++) exp_q.push_back({3'd1, 7'b1000000});
    exp_q.push_back({3'd1, 7'b1010000});
    exp_q.push_back({3'd2, 7'b0001000});
    exp_q.push_back({3'd3, 7'b0000100});
    if (mem) begin
      for (int k = 0; k < dw; k++) exp_q.push_back({3'd4, 7'b0100000});
      exp_q.push_back({3'd4, 7'b0100010});
    end
    exp_q.push_back({3'd5, 7'b0000001});
    dstart = iw + 3;
    wb_idx = exp_q.size() - 1;
    for (int k = 0; k <= wb_idx; k++) begin
      i_imem_ready = (k < iw) ? 1'b0 : (k == iw) ? 1'b1 : 1'($urandom);
      if (mem && k >= dstart && k < dstart + dw) i_dmem_ready = 1'b0;
      else if (mem && k == dstart + dw)          i_dmem_ready = 1'b1;
      else                                       i_dmem_ready = 1'($urandom);
      i_is_mem_op = (k == iw + 1) ? mem : 1'($urandom);
      i_halt_req = (k == halt_at);
      i_run = (k == wb_idx) ? run_wb : 1'($urandom);
      @(negedge i_clk);
      checks++;
      if (obs() !== exp_q[k]) begin
        failures++;
        $display("FAIL instr_trace cycle %0d (mem=%0d iw=%0d dw=%0d): got %b expected %b",
                 k, mem, iw, dw, obs(), exp_q[k]);
      end
      tick();
    end
    i_halt_req = 1'b0;
    exp_count = (exp_count + 1) % (1 << COUNT_W);
    checks++;
    if (o_instr_count !== COUNT_W'(exp_count)) begin
      failures++;
      $display("FAIL instr_count: got %0d expected %0d", o_instr_count, exp_count);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge i_clk);
    checks++;
    if (obs() !== 10'd0 || o_instr_count !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %b count=%0d expected all 0", obs(), o_instr_count);
    end
    check_state("reset_status", 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_basic();
    do_reset();
    start_run();
    run_instr(1'b0, 0, 0, -1, 1'b1);
    i_imem_ready = 1'b0;
    @(negedge i_clk);
    check_state("basic_next_fetch", 3'd1, 1'b1, 1'b0, 1'b0);
    tick();
    // Previous stall cycle is already consumed; continue with the mem op.
    run_instr(1'b1, 0, 3, -1, 1'b1);
  endtask

  task automatic test_halt();
    do_reset();
    start_run();
    run_instr(1'b0, 1, 0, 1 + 2, 1'b1);
    i_run = 1'b1;
    @(negedge i_clk);
    check_state("halt_after_exec_req", 3'd6, 1'b0, 1'b1, 1'b0);
    tick();
    @(negedge i_clk);
    check_state("halt_holds_with_run", 3'd6, 1'b0, 1'b1, 1'b0);
    i_run = 1'b0;
    tick();
    @(negedge i_clk);
    check_state("halt_to_idle", 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    start_run();
    run_instr(1'b1, 0, 2, 0 + 3 + 2 + 1, 1'b1);
    @(negedge i_clk);
    check_state("halt_in_wb", 3'd6, 1'b0, 1'b1, 1'b0);
    i_run = 1'b0;
    tick();
    i_halt_req = 1'b1;
    tick();
    i_halt_req = 1'b0;
    @(negedge i_clk);
    check_state("halt_from_idle", 3'd6, 1'b0, 1'b1, 1'b0);
    tick();
    start_run();
    run_instr(1'b0, 0, 0, -1, 1'b1);
    i_imem_ready = 1'b0;
    @(negedge i_clk);
    check_state("halt_pending_cleared", 3'd1, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_run_drop();
    do_reset();
    start_run();
    run_instr(1'b1, 2, 1, -1, 1'b0);
    i_run = 1'b0;
    @(negedge i_clk);
    check_state("run_drop_idle", 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_run();
    run_instr(1'b0, 0, 0, -1, 1'b1);
    i_imem_ready = 1'b1;
    tick();
    i_is_mem_op = 1'b1;
    tick();
    tick();
    i_dmem_ready = 1'b0;
    @(negedge i_clk);
    check_state("reset_mid_in_mem", 3'd4, 1'b1, 1'b0, 1'b0);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    i_run = 1'b0;
    exp_count = 0;
    checks++;
    if (obs() !== 10'd0 || o_instr_count !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %b count=%0d expected all 0", obs(), o_instr_count);
    end
    @(negedge i_clk);
    checks++;
    if (o_en_WB !== 1'b0 || o_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_mid_no_wb: en_WB=%b state=%0d expected 0/0", o_en_WB, o_state);
    end
    tick();
  endtask

  task automatic test_back_to_back_wrap();
    do_reset();
    start_run();
    for (int n = 1; n <= 20; n++) begin
      run_instr(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, 1'b1);
      if (n == 15) begin
        checks++;
        if (o_instr_count !== 4'hF) begin
          failures++;
          $display("FAIL count_at_15: got %0d expected 15", o_instr_count);
        end
      end
      if (n == 16) begin
        checks++;
        if (o_instr_count !== 4'h0) begin
          failures++;
          $display("FAIL count_wrap: got %0d expected 0", o_instr_count);
        end
      end
    end
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    start_run();
    i_imem_ready = 1'b0;
    for (int k = 0; k < TIMEOUT_CYCLES; k++) begin
      @(negedge i_clk);
      check_state("timeout_waiting", 3'd1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      checks++;
      if (obs() !== {3'd7, 7'b0} || o_fault !== 1'b1 || o_busy !== 1'b0) begin
        failures++;
        $display("FAIL timeout_fault: got %b fault=%b busy=%b expected %b fault=1 busy=0",
                 obs(), o_fault, o_busy, {3'd7, 7'b0});
      end
      i_run = 1'($urandom);
      i_imem_ready = 1'($urandom);
      i_dmem_ready = 1'($urandom);
      i_halt_req = 1'($urandom);
      tick();
    end
    do_reset();
    @(negedge i_clk);
    check_state("timeout_reset_clears", 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    start_run();
    run_instr(1'b0, TIMEOUT_CYCLES - 1, 0, -1, 1'b1);
    run_instr(1'b1, 0, TIMEOUT_CYCLES - 1, -1, 1'b1);
  endtask
`else
  task automatic test_long_wait();
    do_reset();
    start_run();
    run_instr(1'b1, 20, 20, -1, 1'b1);
    checks++;
    if (o_fault !== 1'b0) begin
      failures++;
      $display("FAIL long_wait_no_fault: fault=%b expected 0", o_fault);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_halt();
    test_run_drop();
    test_reset_mid();
    test_back_to_back_wrap();
`ifdef SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
